// File: rtl/store_align_buffer_pkg.sv
// Shared types for the store alignment buffer: store-type encodings,
// byte-enable type and the buffered entry layout.
package store_align_buffer_pkg;

  typedef enum logic [2:0] {
    ST_SB = 3'b000,
    ST_SH = 3'b001,
    ST_SW = 3'b010
  } st_sel_e;

  // Entries keep a full-width word address; narrower configs zero-extend.
  localparam int WORD_W = 30;

  typedef logic [3:0] be_t;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [31:0]       din;
    be_t               we;
  } st_entry_t;

endpackage

// File: rtl/store_align_buffer_if.sv
// Store request, memory write port and load-hazard signals of the store buffer.
interface store_align_buffer_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  st_valid;
  logic                  st_ready;
  logic [2:0]            StSel;
  logic [31:0]           st_addr;
  logic [31:0]           st_data;
  logic                  st_fault;
  logic                  mem_wr_valid;
  logic                  mem_wr_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_din;
  logic [3:0]            mem_we;
  logic [31:0]           ld_addr;
  logic                  ld_hazard;

  modport slave (
    input  st_valid, StSel, st_addr, st_data, mem_wr_ready, ld_addr,
    output st_ready, st_fault, mem_wr_valid, mem_addr, mem_din, mem_we, ld_hazard
  );

  modport master (
    output st_valid, StSel, st_addr, st_data, mem_wr_ready, ld_addr,
    input  st_ready, st_fault, mem_wr_valid, mem_addr, mem_din, mem_we, ld_hazard
  );
endinterface

// File: rtl/store_align_buffer_lane.sv
// Combinational byte-lane steering for SB/SH/SW stores; flags misaligned
// addresses and undefined store types.
module store_lane_align
  import store_align_buffer_pkg::*;
(
  input  logic [2:0]  st_sel,
  input  logic [1:0]  off,
  input  logic [31:0] data,
  output logic [31:0] din,
  output be_t         we,
  output logic        illegal
);

  always_comb begin
    din     = '0;
    we      = '0;
    illegal = 1'b1;
    case (st_sel)
      ST_SB: begin
        din     = {4{data[7:0]}};
        we      = be_t'(4'b0001 << off);
        illegal = 1'b0;
      end
      ST_SH: begin
        din     = {2{data[15:0]}};
        we      = be_t'(4'b0011 << off);
        illegal = off[0];
      end
      ST_SW: begin
        din     = data;
        we      = 4'b1111;
        illegal = (off != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_align_buffer.sv
// In-order store buffer: aligns stores into byte lanes, queues legal ones and
// drains them over a valid/ready write port; reports same-word load hazards.
module store_align_buffer
  import store_align_buffer_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 14
) (
  input logic                  clk,
  input logic                  rst_n,
  store_align_buffer_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             st_fault_q, st_fault_d;
  st_entry_t        entries_q [DEPTH];

  logic [31:0] al_din;
  be_t         al_we;
  logic        al_illegal;
  logic        full, head_valid, accept, enq, deq;
  st_entry_t   new_entry;
  logic [WORD_W-1:0] ld_word;
  logic        hazard;

  store_lane_align u_align (
    .st_sel  (bus.StSel),
    .off     (bus.st_addr[1:0]),
    .data    (bus.st_data),
    .din     (al_din),
    .we      (al_we),
    .illegal (al_illegal)
  );

  function automatic logic [PTR_W-1:0] rel_idx(input logic [PTR_W-1:0] idx,
                                               input logic [PTR_W-1:0] base);
    return idx - base;
  endfunction

  always_comb begin
    full       = (count_q == CNT_W'(DEPTH));
    head_valid = (count_q != '0);
    accept     = bus.st_valid && !full;
    enq        = accept && !al_illegal;
    deq        = head_valid && bus.mem_wr_ready;

    new_entry.addr = WORD_W'(bus.st_addr[ADDR_WIDTH+1:2]);
    new_entry.din  = al_din;
    new_entry.we   = al_we;

    count_d = count_q;
    if (enq && !deq)      count_d = count_q + CNT_W'(1);
    else if (!enq && deq) count_d = count_q - CNT_W'(1);

    wr_ptr_d   = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    st_fault_d = accept && al_illegal;
  end

  // Only slots between rd_ptr and rd_ptr+count hold live stores.
  always_comb begin
    ld_word = WORD_W'(bus.ld_addr[ADDR_WIDTH+1:2]);
    hazard  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(rel_idx(PTR_W'(i), rd_ptr_q)) < count_q) &&
          (entries_q[i].addr == ld_word))
        hazard = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      st_fault_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      st_fault_q <= st_fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) entries_q[wr_ptr_q] <= new_entry;
  end

  assign bus.st_ready     = !full;
  assign bus.st_fault     = st_fault_q;
  assign bus.mem_wr_valid = head_valid;
  assign bus.mem_addr     = head_valid ? entries_q[rd_ptr_q].addr[ADDR_WIDTH-1:0] : '0;
  assign bus.mem_din      = head_valid ? entries_q[rd_ptr_q].din : '0;
  assign bus.mem_we       = head_valid ? entries_q[rd_ptr_q].we : '0;
  assign bus.ld_hazard    = hazard;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.st_addr[31:ADDR_WIDTH+2],
                              bus.ld_addr[31:ADDR_WIDTH+2], bus.ld_addr[1:0]};

endmodule

// File: tb/tb_store_align_buffer.sv
// Self-checking bench for store_align_buffer: directed table, corner sequences
// and random traffic compared against a queue-based reference model.
module tb_store_align_buffer;

  localparam int DEPTH = 2;
  localparam int AW    = 14;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  store_align_buffer_if #(.ADDR_WIDTH(AW)) bus();

  store_align_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [3:0]    w;
  } ment_t;

  ment_t q[$];
  logic  fault_pend = 1'b0;

  typedef struct {
    logic [2:0]    sel;
    logic [31:0]   addr;
    logic [31:0]   data;
    logic          flt;
    logic [3:0]    we;
    logic [31:0]   din;
    logic [AW-1:0] ma;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Store of 2**sel bytes: lanes off..off+size-1, data replicated per size.
  function automatic void ref_align(input logic [2:0] sel, input logic [31:0] addr,
                                    input logic [31:0] data, output logic legal,
                                    output logic [31:0] din, output logic [3:0] we);
    int size, off;
    off   = int'(addr[1:0]);
    legal = 1'b0;
    din   = '0;
    we    = '0;
    if (sel <= 3'd2) begin
      size  = 1 << sel;
      legal = ((off % size) == 0);
      we    = 4'(((1 << size) - 1) << off);
      for (int b = 0; b < 4; b++) din[8*b +: 8] = data[8*(b % size) +: 8];
    end
  endfunction

  task automatic step();
    logic          legal, acc, hz;
    logic [31:0]   din;
    logic [3:0]    we;
    logic [AW-1:0] lw;
    #1;
    lw = AW'(bus.ld_addr >> 2);
    hz = 1'b0;
    foreach (q[i]) if (q[i].a == lw) hz = 1'b1;
    chk("st_ready", 32'(bus.st_ready), 32'(q.size() < DEPTH));
    chk("st_fault", 32'(bus.st_fault), 32'(fault_pend));
    chk("mem_wr_valid", 32'(bus.mem_wr_valid), 32'(q.size() > 0));
    chk("mem_addr", 32'(bus.mem_addr), (q.size() > 0) ? 32'(q[0].a) : 32'd0);
    chk("mem_din", bus.mem_din, (q.size() > 0) ? q[0].d : 32'd0);
    chk("mem_we", 32'(bus.mem_we), (q.size() > 0) ? 32'(q[0].w) : 32'd0);
    chk("ld_hazard", 32'(bus.ld_hazard), 32'(hz));
    acc = bus.st_valid && (q.size() < DEPTH);
    ref_align(bus.StSel, bus.st_addr, bus.st_data, legal, din, we);
    @(posedge clk);
    if (q.size() > 0 && bus.mem_wr_ready) void'(q.pop_front());
    if (acc && legal) q.push_back('{AW'(bus.st_addr >> 2), din, we});
    fault_pend = acc && !legal;
    #1;
  endtask

  task automatic drive(input logic [2:0] sel, input logic [31:0] addr, input logic [31:0] data);
    bus.st_valid = 1'b1;
    bus.StSel    = sel;
    bus.st_addr  = addr;
    bus.st_data  = data;
  endtask

  initial begin
    vt[0] = '{3'b000, 32'h0000_1003, 32'h0000_00AB, 1'b0, 4'b1000, 32'hABAB_ABAB, 14'h400};
    vt[1] = '{3'b001, 32'h0000_1002, 32'h0000_1234, 1'b0, 4'b1100, 32'h1234_1234, 14'h400};
    vt[2] = '{3'b010, 32'h0000_2000, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'hDEAD_BEEF, 14'h800};
    vt[3] = '{3'b010, 32'h0000_1001, 32'h1111_1111, 1'b1, 4'b0000, 32'h0,         14'h0};
    vt[4] = '{3'b001, 32'h0000_1003, 32'h2222_2222, 1'b1, 4'b0000, 32'h0,         14'h0};
    vt[5] = '{3'b011, 32'h0000_1000, 32'h3333_3333, 1'b1, 4'b0000, 32'h0,         14'h0};
    vt[6] = '{3'b000, 32'h0000_0000, 32'hFFFF_FF5A, 1'b0, 4'b0001, 32'h5A5A_5A5A, 14'h000};
    vt[7] = '{3'b001, 32'h0000_0006, 32'hABCD_BEEF, 1'b0, 4'b1100, 32'hBEEF_BEEF, 14'h001};

    rst_n            = 1'b0;
    bus.st_valid     = 1'b0;
    bus.StSel        = 3'b000;
    bus.st_addr      = '0;
    bus.st_data      = '0;
    bus.mem_wr_ready = 1'b0;
    bus.ld_addr      = '0;
    #12;
    chk("rst_valid", 32'(bus.mem_wr_valid), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_din", bus.mem_din, 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_fault", 32'(bus.st_fault), 32'd0);
    chk("rst_ready", 32'(bus.st_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed table: one store into an empty buffer, checked the next cycle.
    bus.mem_wr_ready = 1'b1;
    bus.ld_addr      = 32'h0000_5000;
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].sel, vt[i].addr, vt[i].data);
      step();
      bus.st_valid = 1'b0;
      #1;
      chk($sformatf("tbl%0d_fault", i), 32'(bus.st_fault), 32'(vt[i].flt));
      chk($sformatf("tbl%0d_valid", i), 32'(bus.mem_wr_valid), 32'(!vt[i].flt));
      if (!vt[i].flt) begin
        chk($sformatf("tbl%0d_we", i), 32'(bus.mem_we), 32'(vt[i].we));
        chk($sformatf("tbl%0d_din", i), bus.mem_din, vt[i].din);
        chk($sformatf("tbl%0d_addr", i), 32'(bus.mem_addr), 32'(vt[i].ma));
      end
      step();
      chk($sformatf("tbl%0d_drained", i), 32'(bus.mem_wr_valid), 32'd0);
    end

    // Fill to DEPTH with memory stalled, then drain in order.
    bus.mem_wr_ready = 1'b0;
    drive(3'b010, 32'h0000_0010, 32'h1111_1111);
    step();
    drive(3'b010, 32'h0000_0014, 32'h2222_2222);
    step();
    drive(3'b010, 32'h0000_0018, 32'h3333_3333);
    #1 chk("full_ready_low", 32'(bus.st_ready), 32'd0);
    step();
    chk("full_still_blocked", 32'(bus.st_ready), 32'd0);
    chk("stall_hold_din", bus.mem_din, 32'h1111_1111);
    bus.mem_wr_ready = 1'b1;
    #1 chk("drain_first", bus.mem_din, 32'h1111_1111);
    chk("full_deq_ready_low", 32'(bus.st_ready), 32'd0);
    step();
    chk("drain_second", bus.mem_din, 32'h2222_2222);
    step();
    bus.st_valid = 1'b0;
    chk("drain_third", bus.mem_din, 32'h3333_3333);
    step();
    step();
    chk("drain_empty", 32'(bus.mem_wr_valid), 32'd0);

    // Load hazard against a pending word; same-cycle store excluded.
    bus.mem_wr_ready = 1'b0;
    drive(3'b010, 32'h0000_3000, 32'hCAFE_F00D);
    step();
    bus.st_valid = 1'b0;
    bus.ld_addr  = 32'h0000_3002;
    #1 chk("hazard_same_word", 32'(bus.ld_hazard), 32'd1);
    bus.ld_addr  = 32'h0000_3004;
    #1 chk("hazard_next_word", 32'(bus.ld_hazard), 32'd0);
    drive(3'b010, 32'h0000_3004, 32'h0BAD_0BAD);
    #1 chk("hazard_excl_incoming", 32'(bus.ld_hazard), 32'd0);
    step();
    bus.st_valid = 1'b0;
    chk("hazard_after_enq", 32'(bus.ld_hazard), 32'd1);

    // Reset mid-cycle with two entries pending.
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.mem_wr_valid), 32'd0);
    chk("midrst_ready", 32'(bus.st_ready), 32'd1);
    chk("midrst_we", 32'(bus.mem_we), 32'd0);
    q.delete();
    fault_pend = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.mem_wr_ready = 1'b1;
    repeat (3) step();
    chk("postrst_idle", 32'(bus.mem_wr_valid), 32'd0);

    // Random traffic against the reference model.
    repeat (600) begin
      int r;
      r = int'($urandom_range(0, 9));
      bus.st_valid     = 1'($urandom_range(0, 1));
      bus.StSel        = (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7));
      bus.st_addr      = 32'h3000 + $urandom_range(0, 31) + ($urandom_range(0, 1) << 20);
      bus.st_data      = $urandom;
      bus.ld_addr      = 32'h3000 + $urandom_range(0, 31) + ($urandom_range(0, 1) << 20);
      bus.mem_wr_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
